// File: rtl/weight_bank_pkg.sv
// Shared types and default geometry for the double-buffered weight bank.
// Both copies use the same geometry; only the copy index differs.
package weight_bank_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FILL   = 2'd1,
        LOADED = 2'd2
    } load_state_t;

    localparam int DEF_NUM_BANKS = 8;
    localparam int DEF_WORD_W    = 72;
    localparam int DEF_DEPTH     = 512;
    localparam int DEF_READ_LAT  = 3;

    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
    localparam int DEF_BANK_W = (DEF_NUM_BANKS < 2) ? 1 : $clog2(DEF_NUM_BANKS);

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/weight_bank_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
// The read register only updates on re, so it holds the last word read.
module weight_bank_ram
    import weight_bank_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WORD_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_bank_pingpong.sv
// Double-buffered weight bank: the MAC array reads the active copy while the
// DMA loader fills the shadow copy; a swap handshake exchanges the two.
module weight_bank_pingpong
    import weight_bank_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int READ_LAT  = DEF_READ_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [WORD_W-1:0]           wr_data,
    input  logic                        wr_last,
    output logic                        load_done,
    output logic                        load_ovf,
    input  logic                        swap_req,
    output logic                        swap_ack,
    output logic                        active_sel,
    input  logic                        rd_en,
    input  logic [$clog2(DEPTH)-1:0]    rd_addr,
    input  logic [NUM_BANKS-1:0]        rd_bank_mask,
    output logic                        rd_valid,
    output logic [NUM_BANKS*WORD_W-1:0] rd_data,
    output load_state_t                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = idx_w(NUM_BANKS);

    // Handshakes: a load beat transfers on a cycle with wr_valid & wr_ready;
    // wr_valid/wr_data/wr_last must hold until then. swap_req is a level held
    // until the single-cycle swap_ack, which is high in the commit cycle itself.

    load_state_t       state, state_nx;
    logic [BW-1:0]     wr_bank;
    logic [AW-1:0]     wr_addr;
    logic              wr_copy;
    logic              accept;
    logic              at_end;
    logic              commit;
    logic              rd_busy;

    logic              iss_v;
    logic [AW-1:0]     iss_addr;
    logic [NUM_BANKS-1:0] iss_mask;
    logic              iss_sel;

    logic [NUM_BANKS-1:0] out_mask;
    logic                 out_sel;
    logic [WORD_W-1:0]    bank_q [2][NUM_BANKS];

    assign wr_copy   = ~active_sel;
    assign accept    = wr_valid & wr_ready & ~rst;
    assign at_end    = (wr_bank == BW'(NUM_BANKS - 1)) && (wr_addr == AW'(DEPTH - 1));
    assign commit    = swap_req & (state == LOADED) & ~rd_en & ~rd_busy & ~rst;
    assign swap_ack  = commit;
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        if (commit) begin
            state_nx = EMPTY;
        end else if (accept) begin
            state_nx = (wr_last || at_end) ? LOADED : FILL;
        end
    end

    // Load FSM, write counters and copy select.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            wr_ready   <= 1'b1;
            load_done  <= 1'b0;
            load_ovf   <= 1'b0;
            active_sel <= 1'b0;
            wr_bank    <= '0;
            wr_addr    <= '0;
        end else begin
            state     <= state_nx;
            wr_ready  <= (state_nx != LOADED);
            load_done <= (state_nx == LOADED);
            if (commit) begin
                active_sel <= ~active_sel;
                wr_bank    <= '0;
                wr_addr    <= '0;
                load_ovf   <= 1'b0;
            end else if (accept) begin
                if (wr_bank == BW'(NUM_BANKS - 1)) begin
                    wr_bank <= '0;
                    wr_addr <= wr_addr + AW'(1);
                end else begin
                    wr_bank <= wr_bank + BW'(1);
                end
                if (at_end && !wr_last) begin
                    load_ovf <= 1'b1;
                end
            end
        end
    end

    // Requests wait READ_LAT-1 cycles before hitting the RAM so the RAM read
    // register forms the last stage; a swap is held off while any are queued.
    if (READ_LAT == 1) begin : g_direct
        assign iss_v    = rd_en & ~rst;
        assign iss_addr = rd_addr;
        assign iss_mask = rd_bank_mask;
        assign iss_sel  = active_sel;
        assign rd_busy  = 1'b0;
    end else begin : g_delay
        localparam int STG = READ_LAT - 1;

        logic [STG-1:0]       v_q;
        logic [STG-1:0]       sel_q;
        logic [AW-1:0]        addr_q [STG];
        logic [NUM_BANKS-1:0] mask_q [STG];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= '0;
            end else begin
                v_q[0] <= rd_en;
                for (int s = 1; s < STG; s++) begin
                    v_q[s] <= v_q[s-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            addr_q[0] <= rd_addr;
            mask_q[0] <= rd_bank_mask;
            sel_q[0]  <= active_sel;
            for (int s = 1; s < STG; s++) begin
                addr_q[s] <= addr_q[s-1];
                mask_q[s] <= mask_q[s-1];
                sel_q[s]  <= sel_q[s-1];
            end
        end

        assign iss_v    = v_q[STG-1];
        assign iss_addr = addr_q[STG-1];
        assign iss_mask = mask_q[STG-1];
        assign iss_sel  = sel_q[STG-1];
        assign rd_busy  = |v_q;
    end

    for (genvar c = 0; c < 2; c++) begin : g_copy
        for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
            logic we;
            logic re;

            assign we = accept && (wr_copy == 1'(c)) && (wr_bank == BW'(i));
            assign re = iss_v && iss_mask[i] && (iss_sel == 1'(c));

            weight_bank_ram #(
                .WORD_W(WORD_W),
                .DEPTH (DEPTH)
            ) u_ram (
                .clk  (clk),
                .we   (we),
                .waddr(wr_addr),
                .wdata(wr_data),
                .re   (re),
                .raddr(iss_addr),
                .rdata(bank_q[c][i])
            );
        end
    end

    // out_mask/out_sel only move with a result, so rd_data holds between reads
    // and reads as zero after reset regardless of RAM register contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            out_mask <= '0;
            out_sel  <= 1'b0;
        end else begin
            rd_valid <= iss_v;
            if (iss_v) begin
                out_mask <= iss_mask;
                out_sel  <= iss_sel;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (out_mask[i]) begin
                rd_data[i*WORD_W +: WORD_W] = bank_q[out_sel][i];
            end
        end
    end

endmodule

// File: tb/tb_weight_bank_pingpong.sv
// Directed-plus-random bench for weight_bank_pingpong against a copy/beat-index
// reference model with a timed queue of expected read results.
module tb_weight_bank_pingpong;
    import weight_bank_pkg::*;

    localparam int NB    = 8;
    localparam int W     = 72;
    localparam int DEPTH = 16;
    localparam int RL    = 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = NB * W;
    localparam int CAP   = NB * DEPTH;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [W-1:0]      wr_data = '0;
    logic              wr_last = 1'b0;
    logic              load_done;
    logic              load_ovf;
    logic              swap_req = 1'b0;
    logic              swap_ack;
    logic              active_sel;
    logic              rd_en = 1'b0;
    logic [AW-1:0]     rd_addr = '0;
    logic [NB-1:0]     rd_bank_mask = '0;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    load_state_t       dbg_state;

    weight_bank_pingpong #(
        .NUM_BANKS(NB),
        .WORD_W   (W),
        .DEPTH    (DEPTH),
        .READ_LAT (RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .load_done   (load_done),
        .load_ovf    (load_ovf),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .active_sel  (active_sel),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_bank_mask(rd_bank_mask),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .dbg_state   (dbg_state)
    );

    // reference model: two copies indexed [copy][bank][addr], beat k -> bank k%NB, addr k/NB
    logic [W-1:0]  m_mem [2][NB][DEPTH];
    logic          m_active;
    logic          m_loaded;
    logic          m_ovf;
    int            m_beats;

    // scoreboard
    logic [DW-1:0] exp_q[$];
    int            due_q[$];
    logic [DW-1:0] last_data;
    int            cyc;
    logic          seen_ack;
    int            n_vec = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic [NB-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int b = 0; b < NB; b++) begin
            if (m[b]) r[b*W +: W] = m_mem[m_active][b][a];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, 8'($urandom)};
    endfunction

    // One clock cycle: check outputs against the model, advance, check read results.
    task automatic tick();
        logic          exp_ready;
        logic          exp_commit;
        logic          acc;
        logic [W-1:0]  d;
        logic          last;
        load_state_t   exp_st;
        #1;
        exp_ready  = !m_loaded;
        exp_commit = swap_req && m_loaded && !rd_en && (exp_q.size() == 0);
        exp_st     = m_loaded ? LOADED : ((m_beats > 0) ? FILL : EMPTY);
        chk("wr_ready",   DW'(wr_ready),   DW'(exp_ready));
        chk("load_done",  DW'(load_done),  DW'(m_loaded));
        chk("load_ovf",   DW'(load_ovf),   DW'(m_ovf));
        chk("active_sel", DW'(active_sel), DW'(m_active));
        chk("swap_ack",   DW'(swap_ack),   DW'(exp_commit));
        chk("dbg_state",  DW'(dbg_state),  DW'(exp_st));
        seen_ack = swap_ack;
        acc  = wr_valid && exp_ready;
        d    = wr_data;
        last = wr_last;
        if (rd_en) begin
            exp_q.push_back(model_read(rd_addr, rd_bank_mask));
            due_q.push_back(cyc + RL);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (exp_commit) begin
            m_active = !m_active;
            m_loaded = 1'b0;
            m_beats  = 0;
            m_ovf    = 1'b0;
        end else if (acc) begin
            m_mem[!m_active][m_beats % NB][m_beats / NB] = d;
            m_beats++;
            if (last) begin
                m_loaded = 1'b1;
            end else if (m_beats == CAP) begin
                m_loaded = 1'b1;
                m_ovf    = 1'b1;
            end
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            chk("rd_valid", DW'(rd_valid), DW'(1'b1));
            chk("rd_data", rd_data, exp_q[0]);
            last_data = exp_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            chk("rd_valid_idle", DW'(rd_valid), DW'(1'b0));
            chk("rd_data_hold", rd_data, last_data);
        end
    endtask

    // driver tasks
    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; swap_req = 1'b0; rd_en = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_rd_valid", DW'(rd_valid), DW'(1'b0));
        end
        rst = 1'b0;
        m_active = 1'b0; m_loaded = 1'b0; m_ovf = 1'b0; m_beats = 0;
        exp_q.delete(); due_q.delete();
        last_data = '0;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic last);
        wr_valid = 1'b1; wr_data = d; wr_last = last;
        tick();
        wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic rd(input int a, input logic [NB-1:0] m);
        rd_en = 1'b1; rd_addr = AW'(a); rd_bank_mask = m;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic drain();
        repeat (RL + 1) tick();
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        seen_ack = 1'b0;
        while (!seen_ack && n < limit) begin
            tick();
            n++;
        end
        chk("swap_ack_seen", DW'(seen_ack), DW'(1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acks;
        for (int c = 0; c < 2; c++)
            for (int b = 0; b < NB; b++)
                for (int a = 0; a < DEPTH; a++) m_mem[c][b][a] = '0;
        cyc = 0;
        seen_ack = 1'b0;

        // reset state
        do_reset();
        tick();
        chk("rst_rd_data", rd_data, '0);

        // 1: sixteen-beat load, swap, read two addresses on all banks
        for (int k = 0; k < 16; k++) beat(W'(16 * (k + 1)), k == 15);
        swap_req = 1'b1;
        wait_ack(10, n);
        swap_req = 1'b0;
        chk("active_after_swap1", DW'(active_sel), DW'(1'b1));
        rd(0, 8'hFF);
        rd(1, 8'hFF);
        drain();

        // 2: single-bank mask
        rd(0, 8'h01);
        drain();

        // 3: load while reading continuously; swap deferred until reads drain
        for (int k = 0; k < 16; k++) begin
            rd_en = 1'b1; rd_addr = AW'($urandom_range(0, 1)); rd_bank_mask = NB'($urandom);
            wr_valid = 1'b1; wr_data = {9{8'hAA}} ^ W'(k); wr_last = (k == 15);
            tick();
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        swap_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rd_en = 1'b1; rd_addr = AW'($urandom_range(0, 1)); rd_bank_mask = NB'($urandom);
            tick();
        end
        rd_en = 1'b0;
        wait_ack(10, n);
        swap_req = 1'b0;
        chk("swap_defer_lat", DW'(n), DW'(3));
        rd(0, 8'hFF);
        rd(1, 8'hFF);
        drain();

        // 4: swap requested mid-fill is held until wr_last is accepted
        for (int k = 0; k < 5; k++) beat(rand_word(), 1'b0);
        swap_req = 1'b1;
        acks = 0;
        repeat (6) begin
            tick();
            acks += int'(seen_ack);
        end
        for (int k = 5; k < 16; k++) begin
            beat(rand_word(), k == 15);
            acks += int'(seen_ack);
        end
        chk("fill_ack_cnt", DW'(acks), DW'(0));
        wait_ack(5, n);
        swap_req = 1'b0;
        chk("fill_swap_lat", DW'(n), DW'(1));
        for (int k = 0; k < 4; k++) rd($urandom_range(0, 1), NB'($urandom));
        drain();

        // 5: overflow after CAP beats without wr_last
        for (int t = 0; t < 600 && !m_loaded; t++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = rand_word();
            wr_last  = 1'b0;
            tick();
        end
        wr_valid = 1'b0;
        chk("ovf_set", DW'(load_ovf), DW'(1'b1));
        chk("ovf_wr_ready", DW'(wr_ready), DW'(1'b0));
        for (int k = 0; k < 3; k++) beat(rand_word(), 1'b0);
        swap_req = 1'b1;
        wait_ack(5, n);
        swap_req = 1'b0;
        chk("ovf_cleared", DW'(load_ovf), DW'(1'b0));
        for (int a = 0; a < DEPTH; a++) rd(a, NB'($urandom) | 8'h01);
        drain();

        // 6: reset mid-load with two reads in flight
        for (int k = 0; k < 6; k++) beat(rand_word(), 1'b0);
        for (int k = 0; k < 2; k++) begin
            rd_en = 1'b1; rd_addr = AW'($urandom_range(0, DEPTH - 1)); rd_bank_mask = 8'hFF;
            wr_valid = 1'b1; wr_data = rand_word(); wr_last = 1'b0;
            tick();
        end
        rd_en = 1'b0; wr_valid = 1'b0;
        do_reset();
        chk("rst_active_sel", DW'(active_sel), DW'(1'b0));
        chk("rst_wr_ready", DW'(wr_ready), DW'(1'b1));
        drain();
        for (int k = 0; k < 16; k++) beat(rand_word(), k == 15);
        swap_req = 1'b1;
        wait_ack(5, n);
        swap_req = 1'b0;
        rd(0, 8'hFF);
        rd(1, 8'hFF);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
